pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised chain of pipeline stage registers with per-stage valid bits, backward-propagating stall, per-stage flush, bubble compression and saturating stall/bubble counters. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches into one block. Hazard and branch logic drive it through `stall` and `flush` vectors. The core instantiates it once per payload group.

## Interface
- `WIDTH`, 32, payload bits per stage
- `STAGES`, 4, number of stage registers (≥2); stage 0 youngest, stage STAGES-1 oldest
- `CNT_W`, 16, width of each statistics counter

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `in_valid`  in  1  upstream offers `in_data`
- `in_data`  in  WIDTH  payload entering stage 0
- `in_ready`  out  1  stage 0 accepts this cycle
- `stall`  in  STAGES  `stall[i]` forces stage i to hold
- `flush`  in  STAGES  `flush[i]` kills the entry currently in stage i
- `out_ready`  in  1  downstream consumes stage STAGES-1
- `out_valid`  out  1  stage STAGES-1 holds a live entry
- `out_data`  out  WIDTH  stage STAGES-1 payload
- `stage_valid`  out  STAGES  registered valid bits, raw, before flush masking
- `stage_data`  out  STAGES*WIDTH  flattened stage payloads, stage i at `[i*WIDTH +: WIDTH]`
- `stall_count`  out  CNT_W  cycles with any `stall` bit set, saturating
- `bubble_count`  out  CNT_W  cycles with `out_ready` high and `out_valid` low, saturating

## Operation
- Effective valid: `ev[i] = valid[i] & !flush[i]`. `ev[-1] = in_valid`.
- Hold chain, combinational from oldest to youngest:
  - `hold[STAGES] = !out_ready`
  - `hold[i] = stall[i] | (ev[i] & hold[i+1])`
- An empty stage never propagates hold upstream unless it is itself stalled. This compresses bubbles.
- Next state for stage i:
  - If `hold[i]`: `valid ← ev[i]`, data unchanged.
  - Otherwise: `valid ← ev[i-1] & !hold[i-1]`, `data ← data[i-1]` (stage 0 takes `in_data`).
- A held source sends a bubble downstream. The data is still copied, and the copy is don't-care with valid 0.
- Flush beats everything. A flushed entry never advances and never appears on `out_valid`. A held stage that is flushed becomes empty.
- A flushed stage may accept a new entry from upstream in the same cycle if it is not held.
- `in_ready = !hold[0]`. `out_valid = ev[STAGES-1]`. Retire happens when `out_valid & out_ready`.
- Counters increment by 1 per qualifying cycle and stick at 2^CNT_W−1.
- Reset: all `valid`, `data` and counters go to 0. After reset, `out_valid = 0`. `in_ready = 1` whenever `stall[0]=0`, independent of `out_ready`, because all stages are empty.

## Timing
- Latency: an entry accepted in cycle 0 appears on `out_valid`/`out_data` in cycle STAGES, with no stall or backpressure.
- Throughput: 1 entry per cycle sustained.
- `in_ready` and `out_valid` are combinational in `stall`, `flush` and `out_ready`. There are no combinational paths from `in_valid`/`in_data` to any output.
- Stall and flush apply on the same edge they are sampled. An entry held N cycles adds exactly N cycles of latency.
- Reset asserted mid-stream discards every in-flight entry on that edge. Counters clear on that edge too.
- `stall[i]` and `flush[i]` asserted together on the same stage: the stage empties, and upstream stays held through `stall[i]`.

## Structure
- Package `pipe_pkg`:
  - default `WIDTH`/`STAGES`/`CNT_W` constants
  - saturating-increment function
- Sub-module `pipe_stage`:
  - one valid+data register
  - inputs `hold`, `flush`, upstream `ev`, `hold`, data
  - outputs `valid`, `data`, `ev`
- `pipe_stage_chain` generates STAGES instances, plus the hold chain and counters.

## Test plan
- **Plain flow** (STAGES=4): `in_data` 0x10..0x17 on 8 consecutive cycles, `out_ready=1` → same sequence on `out_data` in cycles 4..11; `stall_count=0`; `bubble_count=4`, covering cycles 0..3.
- **Backpressure with compression**: three entries A, B, C separated by one idle cycle each, then `out_ready=0` for 6 cycles → stages fill to A, B, C plus one more entry; `in_ready` drops only once all 4 stages are valid; release → A, B, C retire in order with no loss or duplication.
- **Mid stall**: `stall[1]=1` for 3 cycles during steady flow → stage 2 receives 3 bubbles; stage 0 holds; `stall_count=3`; output resumes in order.
- **Branch flush**: `flush[0]` and `flush[1]` pulsed one cycle while entries 0x20..0x23 are in flight → the two youngest live entries never appear on the output; the older two retire normally.
- **Reset mid-operation**: 4 valid entries plus nonzero counters, `reset` high for one cycle → next cycle `stage_valid=0`, `out_valid=0`, both counters 0, `in_ready=1`.
- **Saturation** (CNT_W=4): hold `stall[0]=1` for 20 cycles → `stall_count` stays at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - default geometry and saturating counter helper for the stage chain
package pipe_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_CNT_W  = 16;

    // Counters up to 32 bits wide; the value sticks at 2^width-1
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// rtl/pipe_stage_chain_if.sv - upstream/downstream handshake bundle of the stage chain
interface pipe_stage_chain_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid+data pipeline register with hold and flush
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             up_ev,
    input  logic             up_hold,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ev
);

    assign ev = valid & ~flush;

    // A held source leaves a bubble here; its data is still copied as don't-care
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (hold) begin
            valid <= ev;
        end else begin
            valid <= up_ev & ~up_hold;
            data  <= up_data;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - stage register chain with backward stall, flush, bubble compression and stats
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clock,
    input  logic                    reset,
    pipe_stage_chain_if.slave       bus,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    output logic [STAGES-1:0]       stage_valid,
    output logic [STAGES*WIDTH-1:0] stage_data,
    output logic [CNT_W-1:0]        stall_count,
    output logic [CNT_W-1:0]        bubble_count
);

    logic [STAGES-1:0]       ev;
    logic [STAGES-1:0]       up_ev;
    logic [STAGES-1:0]       up_hold;
    logic [STAGES:0]         hold;
    logic [STAGES*WIDTH-1:0] up_data;

    // Empty stages break the chain, so downstream pressure only reaches live entries
    always_comb begin
        hold         = '0;
        hold[STAGES] = ~bus.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            hold[i] = stall[i] | (ev[i] & hold[i+1]);
        end
    end

    assign up_ev   = {ev[STAGES-2:0], bus.in_valid};
    assign up_hold = {hold[STAGES-2:0], 1'b0};
    assign up_data = {stage_data[(STAGES-1)*WIDTH-1:0], bus.in_data};

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clock   (clock),
            .reset   (reset),
            .hold    (hold[i]),
            .flush   (flush[i]),
            .up_ev   (up_ev[i]),
            .up_hold (up_hold[i]),
            .up_data (up_data[i*WIDTH +: WIDTH]),
            .valid   (stage_valid[i]),
            .data    (stage_data[i*WIDTH +: WIDTH]),
            .ev      (ev[i])
        );
    end

    assign bus.in_ready  = ~hold[0];
    assign bus.out_valid = ev[STAGES-1];
    assign bus.out_data  = stage_data[(STAGES-1)*WIDTH +: WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (|stall) begin
                stall_count <= CNT_W'(sat_inc(32'(stall_count), CNT_W));
            end
            if (bus.out_ready & ~bus.out_valid) begin
                bubble_count <= CNT_W'(sat_inc(32'(bubble_count), CNT_W));
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - randomized self-checking bench for pipe_stage_chain
module tb_pipe_stage_chain;

    localparam int W = 32;
    localparam int S = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [S-1:0]   stall, flush;
    logic [S-1:0]   sv, sv4;
    logic [S*W-1:0] sd, sd4;
    logic [15:0]    sc, bc;
    logic [3:0]     sc4, bc4;

    pipe_stage_chain_if #(.WIDTH(W)) bus ();
    pipe_stage_chain_if #(.WIDTH(W)) bus4 ();

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_data   = bus.in_data;
    assign bus4.out_ready = bus.out_ready;

    pipe_stage_chain #(.WIDTH(W), .STAGES(S), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .bus(bus), .stall(stall), .flush(flush),
        .stage_valid(sv), .stage_data(sd), .stall_count(sc), .bubble_count(bc)
    );

    pipe_stage_chain #(.WIDTH(W), .STAGES(S), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .bus(bus4), .stall(stall), .flush(flush),
        .stage_valid(sv4), .stage_data(sd4), .stall_count(sc4), .bubble_count(bc4)
    );

    int checks;
    int failures;
    int cyc;

    bit         mv[S];
    logic [W-1:0] md[S];
    int         raw_stall;
    int         raw_bubble;

    logic [W-1:0] acc_q[$];
    logic [W-1:0] ret_q[$];
    int           ret_cyc[$];

    function automatic int sat(input int raw, input int w);
        int m;
        m = (1 << w) - 1;
        return (raw > m) ? m : raw;
    endfunction

    // Reference: whole-pipeline snapshot advanced one clock using the chain rules
    task automatic tick();
        bit           ev[S];
        bit           h[S+1];
        bit           nv[S];
        logic [W-1:0] nd[S];
        logic [S-1:0]   e_sv;
        logic [S*W-1:0] e_sd;
        bit r, any_stall, bubble;
        for (int i = 0; i < S; i++) ev[i] = mv[i] & !flush[i];
        h[S] = !bus.out_ready;
        for (int i = S - 1; i >= 0; i--) h[i] = stall[i] | (ev[i] & h[i+1]);
        for (int i = 0; i < S; i++) begin
            e_sv[i] = mv[i];
            e_sd[i*W +: W] = md[i];
            if (h[i]) begin
                nv[i] = ev[i];
                nd[i] = md[i];
            end else if (i == 0) begin
                nv[i] = bus.in_valid;
                nd[i] = bus.in_data;
            end else begin
                nv[i] = ev[i-1] & !h[i-1];
                nd[i] = md[i-1];
            end
        end
        r = reset;
        any_stall = |stall;
        bubble = bus.out_ready && !ev[S-1];
        #3;
        checks++; if (bus.in_ready !== !h[0]) begin failures++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, !h[0]); end
        checks++; if (bus.out_valid !== ev[S-1]) begin failures++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, ev[S-1]); end
        if (ev[S-1]) begin
            checks++; if (bus.out_data !== md[S-1]) begin failures++; $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, bus.out_data, md[S-1]); end
        end
        checks++; if (sv !== e_sv) begin failures++; $display("FAIL stage_valid cyc=%0d got=%b exp=%b", cyc, sv, e_sv); end
        checks++; if (sd !== e_sd) begin failures++; $display("FAIL stage_data cyc=%0d got=%h exp=%h", cyc, sd, e_sd); end
        checks++; if (sc !== 16'(sat(raw_stall, 16))) begin failures++; $display("FAIL stall_count cyc=%0d got=%0d exp=%0d", cyc, sc, sat(raw_stall, 16)); end
        checks++; if (bc !== 16'(sat(raw_bubble, 16))) begin failures++; $display("FAIL bubble_count cyc=%0d got=%0d exp=%0d", cyc, bc, sat(raw_bubble, 16)); end
        checks++; if (bus4.in_ready !== !h[0]) begin failures++; $display("FAIL in_ready4 cyc=%0d got=%b exp=%b", cyc, bus4.in_ready, !h[0]); end
        checks++; if (bus4.out_valid !== ev[S-1]) begin failures++; $display("FAIL out_valid4 cyc=%0d got=%b exp=%b", cyc, bus4.out_valid, ev[S-1]); end
        if (ev[S-1]) begin
            checks++; if (bus4.out_data !== md[S-1]) begin failures++; $display("FAIL out_data4 cyc=%0d got=%h exp=%h", cyc, bus4.out_data, md[S-1]); end
        end
        checks++; if (sv4 !== e_sv || sd4 !== e_sd) begin failures++; $display("FAIL stages4 cyc=%0d got=%b/%h exp=%b/%h", cyc, sv4, sd4, e_sv, e_sd); end
        checks++; if (sc4 !== 4'(sat(raw_stall, 4))) begin failures++; $display("FAIL stall_count4 cyc=%0d got=%0d exp=%0d", cyc, sc4, sat(raw_stall, 4)); end
        checks++; if (bc4 !== 4'(sat(raw_bubble, 4))) begin failures++; $display("FAIL bubble_count4 cyc=%0d got=%0d exp=%0d", cyc, bc4, sat(raw_bubble, 4)); end
        if (bus.in_valid && bus.in_ready) acc_q.push_back(bus.in_data);
        if (bus.out_valid && bus.out_ready) begin
            ret_q.push_back(bus.out_data);
            ret_cyc.push_back(cyc);
        end
        @(posedge clock);
        if (r) begin
            for (int i = 0; i < S; i++) begin
                mv[i] = 1'b0;
                md[i] = '0;
            end
            raw_stall = 0;
            raw_bubble = 0;
        end else begin
            for (int i = 0; i < S; i++) begin
                mv[i] = nv[i];
                md[i] = nd[i];
            end
            if (any_stall) raw_stall++;
            if (bubble) raw_bubble++;
        end
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        stall = '0;
        flush = '0;
        tick();
        reset = 1'b0;
        acc_q.delete();
        ret_q.delete();
        ret_cyc.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (sv !== '0) begin failures++; $display("FAIL rst_stage_valid got=%b exp=0", sv); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (sc !== 16'd0 || bc !== 16'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", sc, bc); end
        stall = 4'b0001;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_stall0_in_ready got=%b exp=0", bus.in_ready); end
        stall = '0;
    endtask

    task automatic test_plain_flow();
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus.in_valid = (k < 8);
            bus.in_data = (k < 8) ? 32'h10 + 32'(k) : $urandom;
            tick();
        end
        checks++; if (bc !== 16'd4) begin failures++; $display("FAIL plain_bubbles got=%0d exp=4", bc); end
        checks++; if (sc !== 16'd0) begin failures++; $display("FAIL plain_stalls got=%0d exp=0", sc); end
        checks++; if (ret_q.size() != 8) begin failures++; $display("FAIL plain_count got=%0d exp=8", ret_q.size()); end
        for (int k = 0; k < 8 && k < ret_q.size(); k++) begin
            checks++;
            if (ret_q[k] !== 32'h10 + 32'(k) || ret_cyc[k] != 4 + k) begin
                failures++;
                $display("FAIL plain_order idx=%0d got=%h@%0d exp=%h@%0d", k, ret_q[k], ret_cyc[k], 32'h10 + k, 4 + k);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, c, d0;
        a = $urandom; b = $urandom; c = $urandom; d0 = $urandom;
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 11; k++) begin
            bus.in_valid = (k == 0 || k == 2 || k >= 4);
            case (k)
                0: bus.in_data = a;
                2: bus.in_data = b;
                4: bus.in_data = c;
                5: bus.in_data = d0;
                default: bus.in_data = $urandom;
            endcase
            #1;
            checks++; if (bus.in_ready !== !(&sv)) begin failures++; $display("FAIL bp_in_ready k=%0d got=%b valid=%b", k, bus.in_ready, sv); end
            tick();
        end
        checks++; if (sv !== 4'b1111 || sd !== {a, b, c, d0}) begin failures++; $display("FAIL bp_fill got=%b/%h exp=1111/%h", sv, sd, {a, b, c, d0}); end
        checks++; if (acc_q.size() != 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", acc_q.size()); end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        repeat (6) tick();
        checks++;
        if (ret_q.size() != 4 || ret_q[0] !== a || ret_q[1] !== b || ret_q[2] !== c || ret_q[3] !== d0) begin
            failures++;
            $display("FAIL bp_retire got_n=%0d exp_n=4 exp=%h %h %h %h", ret_q.size(), a, b, c, d0);
        end
    endtask

    task automatic test_mid_stall();
        logic [W-1:0] base;
        base = $urandom;
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 22; k++) begin
            bus.in_valid = (k < 12);
            bus.in_data = base + 32'(acc_q.size());
            stall = (k >= 5 && k <= 7) ? 4'b0010 : 4'b0000;
            #1;
            checks++; if (bus.in_ready !== !(k >= 5 && k <= 7)) begin failures++; $display("FAIL ms_in_ready k=%0d got=%b", k, bus.in_ready); end
            if (k >= 3 && k <= 14) begin
                checks++; if (sv[2] !== !(k >= 6 && k <= 8)) begin failures++; $display("FAIL ms_stage2 k=%0d got=%b", k, sv[2]); end
            end
            tick();
        end
        checks++; if (sc !== 16'd3) begin failures++; $display("FAIL ms_stall_count got=%0d exp=3", sc); end
        checks++; if (acc_q.size() != 9) begin failures++; $display("FAIL ms_accepted got=%0d exp=9", acc_q.size()); end
        checks++; if (ret_q.size() != acc_q.size()) begin failures++; $display("FAIL ms_retired got=%0d exp=%0d", ret_q.size(), acc_q.size()); end
        for (int i = 0; i < ret_q.size() && i < acc_q.size(); i++) begin
            checks++; if (ret_q[i] !== base + 32'(i)) begin failures++; $display("FAIL ms_order idx=%0d got=%h exp=%h", i, ret_q[i], base + 32'(i)); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = (k < 4);
            bus.in_data = 32'h20 + 32'(k);
            flush = (k == 4) ? 4'b0011 : 4'b0000;
            #1;
            if (k == 4) begin
                checks++; if (sv !== 4'b1111) begin failures++; $display("FAIL fl_raw_valid got=%b exp=1111", sv); end
            end
            tick();
        end
        flush = '0;
        checks++;
        if (ret_q.size() != 2 || ret_q[0] !== 32'h20 || ret_q[1] !== 32'h21) begin
            failures++;
            $display("FAIL fl_retire got_n=%0d exp_n=2 exp=20 21", ret_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b1;
        tick();
        stall = 4'b1000;
        tick();
        stall = '0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.in_data = $urandom;
            tick();
        end
        checks++; if (sv !== 4'b1111 || sc !== 16'd1 || bc !== 16'd2) begin failures++; $display("FAIL rm_before got=%b/%0d/%0d exp=1111/1/2", sv, sc, bc); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (sv !== '0 || sd !== '0) begin failures++; $display("FAIL rm_stages got=%b/%h exp=0/0", sv, sd); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (sc !== 16'd0 || bc !== 16'd0) begin failures++; $display("FAIL rm_counters got=%0d/%0d exp=0/0", sc, bc); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rm_in_ready got=%b exp=1", bus.in_ready); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        bus.out_ready = 1'b1;
        stall = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            bus.in_valid = $urandom_range(0, 1) == 1;
            bus.in_data = $urandom;
            tick();
        end
        stall = '0;
        checks++; if (sc4 !== 4'd15) begin failures++; $display("FAIL sat_stall4 got=%0d exp=15", sc4); end
        checks++; if (sc !== 16'd20) begin failures++; $display("FAIL sat_stall16 got=%0d exp=20", sc); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bus.in_valid = $urandom_range(0, 3) != 0;
            bus.in_data = $urandom;
            bus.out_ready = $urandom_range(0, 3) != 0;
            stall = S'($urandom) & S'($urandom) & S'($urandom);
            flush = S'($urandom) & S'($urandom) & S'($urandom) & S'($urandom);
            tick();
        end
        stall = '0;
        flush = '0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        raw_stall = 0;
        raw_bubble = 0;
        for (int i = 0; i < S; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        stall = '0;
        flush = '0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_plain_flow();
        test_backpressure();
        test_mid_stall();
        test_flush();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
